// File: rtl/mc_alu_sequencer.sv
// Multi-cycle MIPS control FSM around a shared 4-bit-opcode ALU; outputs decode the state and latched IR.
// Latency: 3-5 cycles per instruction plus memory wait cycles; one retire pulse per instruction.
// Backpressure: memory states hold until mem_ready; TIMEOUT wait cycles without it halt with sticky err.
module mc_alu_sequencer #(
    parameter int PC_W    = 10,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        alu_src,
    output logic [3:0]  alu_op,
    output logic        ext_zero,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        retire,
    output logic        err,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'h0,
        S_DECODE   = 4'h1,
        S_EXEC_R   = 4'h2,
        S_EXEC_I   = 4'h3,
        S_MEM_ADDR = 4'h4,
        S_MEM_RD   = 4'h5,
        S_MEM_WR   = 4'h6,
        S_WB       = 4'h7,
        S_BRANCH   = 4'h8,
        S_JUMP     = 4'h9,
        S_HALT     = 4'hF
    } state_t;

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam int unused_pc_w = PC_W;

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] to_q, to_d;
    logic             active_q;
    logic [11:0]      ir_q;
    logic [5:0]       opcode, funct;
    logic [3:0]       r_op;
    logic             r_legal;
    logic             waiting;
    logic             unused_instr;

    assign opcode       = ir_q[11:6];
    assign funct        = ir_q[5:0];
    assign err          = err_q;
    assign state        = state_q;
    assign unused_instr = ^instr[25:6];

    always_comb begin
        r_op    = 4'h0;
        r_legal = 1'b1;
        case (funct)
            6'h20:   r_op = 4'h1;
            6'h21:   r_op = 4'h2;
            6'h22:   r_op = 4'h3;
            6'h23:   r_op = 4'h4;
            6'h24:   r_op = 4'h5;
            6'h25:   r_op = 4'h6;
            6'h27:   r_op = 4'h7;
            6'h2A:   r_op = 4'h8;
            6'h00:   r_op = 4'h9;
            6'h02:   r_op = 4'hA;
            6'h03:   r_op = 4'hB;
            6'h08:   r_op = 4'hC;
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        to_d       = '0;
        waiting    = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 4'h0;
        ext_zero   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        retire     = 1'b0;

        case (state_q)
            S_FETCH: begin
                // The first cycle out of reset stays quiet so mem_req rises one clock after release.
                mem_req = active_q;
                if (active_q && mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    waiting = active_q;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                          state_d = S_EXEC_R;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    default: begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_op = r_op;
                if (!r_legal) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else if (funct == FN_JR) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd3;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    reg_dst = 1'b1;
                    state_d = S_WB;
                end
            end
            S_EXEC_I: begin
                alu_src = 1'b1;
                case (opcode)
                    OP_ADDI:  alu_op = 4'h1;
                    OP_ADDIU: alu_op = 4'h2;
                    OP_ANDI:  alu_op = 4'h5;
                    OP_ORI:   alu_op = 4'h6;
                    default:  alu_op = 4'h0;
                endcase
                ext_zero = (opcode == OP_ANDI) || (opcode == OP_ORI);
                state_d  = S_WB;
            end
            S_MEM_ADDR: begin
                alu_src = 1'b1;
                alu_op  = 4'h2;
                state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
                // Address computation is held so the ALU result stays valid across the wait.
                mem_req = 1'b1;
                iord    = 1'b1;
                alu_src = 1'b1;
                alu_op  = 4'h2;
                mem_we  = (state_q == S_MEM_WR);
                if (mem_ready) begin
                    if (state_q == S_MEM_RD) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                mem_to_reg = (opcode == OP_LW);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_op = (opcode == OP_BNE) ? 4'hD : 4'h3;
                if (zero) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd1;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end
        endcase

        if (waiting) begin
            if (to_q == TO_LAST) begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            err_q    <= 1'b0;
            to_q     <= '0;
            active_q <= 1'b0;
            ir_q     <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            to_q     <= to_d;
            active_q <= 1'b1;
            if (ir_write) begin
                ir_q <= {instr[31:26], instr[5:0]};
            end
        end
    end

endmodule
